// File: rtl/pulse_pkg.sv
// pulse_pkg: shared descriptor layout, register map and FSM states for the pulse descriptor writer.
package pulse_pkg;
  localparam int DW = 32;
  localparam logic [2:0] REG_CH      = 3'd0;
  localparam logic [2:0] REG_AMP     = 3'd1;
  localparam logic [2:0] REG_DUR     = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_PUSHCNT = 3'd5;
  typedef enum logic {IDLE, PEND} state_t;
  typedef struct packed {
    logic [15:0] dur;
    logic [11:0] amp;
    logic [3:0]  ch;
  } pulse_desc_t;
  function automatic pulse_desc_t pack_desc(logic [3:0] ch, logic [11:0] amp, logic [15:0] dur);
    return '{dur: dur, amp: amp, ch: ch};
  endfunction
endpackage

// File: rtl/pulse_desc_writer.sv
// pulse_desc_writer: MMIO-staged pulse descriptor, pushed into a dual-clock FIFO one at a time.
module pulse_desc_writer
  import pulse_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DROPW = 8
) (
  input  logic          clk_wr,
  input  logic          rst_wr,
  input  logic          bus_valid,
  input  logic          bus_we,
  input  logic [2:0]    bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic [31:0]   bus_rdata,
  output logic          bus_rvalid,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  input  logic          fifo_full,
  output logic          pending
);
  state_t            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [11:0]       amp_q, amp_d;
  logic [15:0]       dur_q, dur_d;
  pulse_desc_t       desc_q, desc_d;
  logic [DROPW-1:0]  drop_q, drop_d;
  logic [15:0]       push_cnt_q, push_cnt_d;
  logic [31:0]       rdata_q, rdata_d, rd_val;
  logic              rvalid_q;
  logic              wr, rd, commit, clr;
  assign wr     = bus_valid & bus_we;
  assign rd     = bus_valid & ~bus_we;
  assign commit = wr & (bus_addr == REG_CTRL) & bus_wdata[0];
  assign clr    = wr & (bus_addr == REG_CTRL) & bus_wdata[1];
  assign pending      = (state_q == PEND);
  assign fifo_wr_en   = pending & ~fifo_full;
  assign fifo_wr_data = DW'(desc_q);
  assign bus_rdata    = rdata_q;
  assign bus_rvalid   = rvalid_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && commit) state_d = PEND;
    else if (fifo_wr_en) state_d = IDLE;
  end
  // Fields are sampled from the _q copies so a same-cycle field write packs the old value.
  always_comb begin
    ch_d       = (wr && bus_addr == REG_CH)  ? bus_wdata[3:0]  : ch_q;
    amp_d      = (wr && bus_addr == REG_AMP) ? bus_wdata[11:0] : amp_q;
    dur_d      = (wr && bus_addr == REG_DUR) ? bus_wdata[15:0] : dur_q;
    desc_d     = (state_q == IDLE && commit) ? pack_desc(ch_q, amp_q, dur_q) : desc_q;
    push_cnt_d = fifo_wr_en ? push_cnt_q + 16'd1 : push_cnt_q;
    drop_d     = clr ? '0 : (pending && commit && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  always_comb begin
    rd_val = '0;
    case (bus_addr)
      REG_CH:      rd_val = 32'(ch_q);
      REG_AMP:     rd_val = 32'(amp_q);
      REG_DUR:     rd_val = 32'(dur_q);
      REG_STATUS:  rd_val = {16'd0, 8'(drop_q), 6'd0, pending, fifo_full};
      REG_PUSHCNT: rd_val = 32'(push_cnt_q);
      default:     rd_val = '0;
    endcase
    rdata_d = rd ? rd_val : rdata_q;
  end
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      amp_q      <= '0;
      dur_q      <= '0;
      desc_q     <= '0;
      drop_q     <= '0;
      push_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      amp_q      <= amp_d;
      dur_q      <= dur_d;
      desc_q     <= desc_d;
      drop_q     <= drop_d;
      push_cnt_q <= push_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rd;
    end
  end
endmodule

// File: tb/tb_pulse_desc_writer.sv
// tb_pulse_desc_writer: scoreboard bench for reads and FIFO pushes of pulse_desc_writer.
module tb_pulse_desc_writer;
  logic        clk_wr = 0, rst_wr = 1;
  logic        bus_valid = 0, bus_we = 0;
  logic [2:0]  bus_addr = 0;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic        bus_rvalid, fifo_wr_en, fifo_full = 0, pending;
  logic [31:0] fifo_wr_data;
  int          errs = 0, checks = 0;
  logic [31:0] rd_q[$], desc_q[$];
  logic [31:0] exp_d;

  pulse_desc_writer dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .pending(pending)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk_wr) begin
    if (!rst_wr && bus_rvalid) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rdata", bus_rdata, rd_q.pop_front());
    end
    if (fifo_wr_en) begin
      if (desc_q.size() == 0) check("push_unexpected", 1, 0);
      else check("push_data", fifo_wr_data, desc_q.pop_front());
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk_wr);
    #1;
  endtask

  task automatic bus_write(logic [2:0] a, logic [31:0] d);
    bus_valid = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
    idle(1);
    bus_valid = 0; bus_we = 0;
  endtask

  task automatic bus_read(logic [2:0] a, logic [31:0] exp);
    bus_valid = 1; bus_we = 0; bus_addr = a;
    rd_q.push_back(exp);
    idle(1);
    bus_valid = 0;
  endtask

  task automatic set_fields(logic [3:0] ch, logic [11:0] amp, logic [15:0] dur);
    bus_write(3'd0, 32'(ch));
    bus_write(3'd1, 32'(amp));
    bus_write(3'd2, 32'(dur));
    exp_d = {dur, amp, ch};
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 8; i++) bus_read(3'(i), 32'd0);
  endtask

  initial begin
    idle(2);
    rst_wr = 0;
    idle(1);
    check("rst_pending", 32'(pending), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_data", fifo_wr_data, 0);
    read_all_zero();
    idle(1);
    check("rvalid_one_cycle", 32'(bus_rvalid), 0);

    // basic push
    set_fields(4'd3, 12'h7FF, 16'd100);
    check("pack_const", exp_d, 32'h00647FF3);
    desc_q.push_back(32'h00647FF3);
    bus_write(3'd3, 32'h1);
    check("wr_en_latency", 32'(fifo_wr_en), 1);
    idle(1);
    check("wr_en_single", 32'(fifo_wr_en), 0);
    check("idle_after_push", 32'(pending), 0);
    bus_read(3'd5, 32'd1);
    bus_write(3'd5, 32'h1234);
    bus_write(3'd4, 32'hFFFF);
    bus_read(3'd5, 32'd1);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd0, 32'hF);
    bus_read(3'd1, 32'hFFF);
    bus_read(3'd2, 32'd100);
    bus_read(3'd3, 32'd0);
    bus_read(3'd6, 32'd0);

    // backpressure, drops, clear priority
    set_fields(4'd5, 12'h123, 16'hBEEF);
    fifo_full = 1;
    desc_q.push_back(exp_d);
    bus_write(3'd3, 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("bp_pending", 32'(pending), 1);
      check("bp_wr_en", 32'(fifo_wr_en), 0);
      check("bp_data", fifo_wr_data, 32'hBEEF1235);
      idle(1);
    end
    bus_read(3'd4, 32'h0003);
    for (int i = 0; i < 300; i++) bus_write(3'd3, 32'h1);
    bus_read(3'd4, 32'hFF03);
    check("drop_data_stable", fifo_wr_data, 32'hBEEF1235);
    bus_write(3'd3, 32'h2);
    bus_read(3'd4, 32'h0003);
    bus_write(3'd3, 32'h1);
    bus_write(3'd3, 32'h3);
    bus_read(3'd4, 32'h0003);
    fifo_full = 0;
    #1;
    check("bp_release_wr_en", 32'(fifo_wr_en), 1);
    idle(1);
    check("bp_after_pending", 32'(pending), 0);
    idle(3);
    bus_read(3'd5, 32'd2);

    // commit during the push cycle
    set_fields(4'd9, 12'hABC, 16'h1357);
    desc_q.push_back(exp_d);
    bus_write(3'd3, 32'h1);
    check("same_wr_en", 32'(fifo_wr_en), 1);
    bus_write(3'd3, 32'h1);
    check("same_idle", 32'(pending), 0);
    idle(2);
    bus_read(3'd4, 32'h0100);
    bus_read(3'd5, 32'd3);

    // reset while pending and full
    fifo_full = 1;
    bus_write(3'd3, 32'h1);
    check("pre_rst_pending", 32'(pending), 1);
    rst_wr = 1;
    #1;
    check("rst_mid_pending", 32'(pending), 0);
    check("rst_mid_wr_en", 32'(fifo_wr_en), 0);
    check("rst_mid_data", fifo_wr_data, 0);
    idle(1);
    rst_wr = 0;
    fifo_full = 0;
    idle(2);
    check("post_rst_wr_en", 32'(fifo_wr_en), 0);
    read_all_zero();

    // PUSHCNT wrap: preload the counter near the top, then push across the boundary
    force dut.push_cnt_q = 16'hFFF0;
    #1;
    release dut.push_cnt_q;
    idle(1);
    bus_read(3'd5, 32'hFFF0);
    set_fields(4'd1, 12'h001, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      desc_q.push_back(exp_d);
      bus_write(3'd3, 32'h1);
      idle(1);
    end
    bus_read(3'd5, 32'd0);
    desc_q.push_back(exp_d);
    bus_write(3'd3, 32'h1);
    idle(1);
    bus_read(3'd5, 32'd1);
    idle(3);
    check("rd_queue_empty", 32'(rd_q.size()), 0);
    check("desc_queue_empty", 32'(desc_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
